// File: rtl/dijkstra_path_tracer.sv
// dijkstra_path_tracer: snapshots solver results and streams predecessor-chain paths source-first
module dijkstra_path_tracer #(
    parameter int MAX_VIRTEX_NUM   = 16,
    parameter int VIRTEX_NUM_WIDTH = 4,
    parameter int VIRTEX_DWIDTH    = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       result_rdy_i,
    input  logic [VIRTEX_DWIDTH*MAX_VIRTEX_NUM-1:0]    dist_vect_i,
    input  logic [VIRTEX_NUM_WIDTH*MAX_VIRTEX_NUM-1:0] route_vect_i,
    input  logic [VIRTEX_NUM_WIDTH-1:0]                src_virt_i,
    input  logic [VIRTEX_NUM_WIDTH:0]                  virt_num_i,
    input  logic                                       req_valid_i,
    input  logic [VIRTEX_NUM_WIDTH-1:0]                req_dst_i,
    output logic                                       req_ready_o,
    output logic                                       path_valid_o,
    input  logic                                       path_ready_i,
    output logic [VIRTEX_NUM_WIDTH-1:0]                path_virt_o,
    output logic [VIRTEX_DWIDTH-1:0]                   path_dist_o,
    output logic                                       path_last_o,
    output logic                                       trace_err_o,
    output logic [1:0]                                 err_code_o,
    output logic                                       busy_o,
    output logic                                       loaded_o,
    output logic                                       snap_ovr_o
);
    localparam int VW = VIRTEX_NUM_WIDTH;
    localparam int DW = VIRTEX_DWIDTH;
    localparam logic [VW:0]   SP_ONE = 1;
    localparam logic [VW-1:0] V_ONE  = 1;

    typedef enum logic [1:0] {IDLE, WALK, EMIT, ERR} state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  dist_q  [MAX_VIRTEX_NUM];
    logic [VW-1:0]  route_q [MAX_VIRTEX_NUM];
    logic [VW-1:0]  stack_q [MAX_VIRTEX_NUM];
    logic [VW-1:0]  src_q, cur_q, cur_d, top;
    logic [VW:0]    num_q, sp_q, sp_d;
    logic [1:0]     code_q, code_d;
    logic           loaded_q, ovr_q, snap, accept, bad_dst, emit;

    assign snap         = result_rdy_i && state_q == IDLE;
    assign req_ready_o  = state_q == IDLE && !result_rdy_i;
    assign accept       = req_valid_i && req_ready_o;
    assign bad_dst      = {1'b0, req_dst_i} >= num_q;
    assign top          = sp_q[VW-1:0] - V_ONE;
    assign emit         = state_q == EMIT;
    assign path_valid_o = emit;
    assign path_virt_o  = emit ? stack_q[top] : '0;
    assign path_dist_o  = emit ? dist_q[stack_q[top]] : '0;
    assign path_last_o  = emit && sp_q == SP_ONE;
    assign trace_err_o  = state_q == ERR;
    assign err_code_o   = trace_err_o ? code_q : 2'd0;
    assign busy_o       = state_q != IDLE;
    assign loaded_o     = loaded_q;
    assign snap_ovr_o   = ovr_q;

    // next-state: error triage on accept, one push per WALK cycle, pop per EMIT handshake
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        sp_d    = sp_q;
        code_d  = code_q;
        case (state_q)
            IDLE: if (accept) begin
                cur_d   = req_dst_i;
                sp_d    = '0;
                code_d  = !loaded_q ? 2'd0 : bad_dst ? 2'd1 : 2'd2;
                state_d = (!loaded_q || bad_dst || &dist_q[req_dst_i]) ? ERR : WALK;
            end
            WALK: begin
                sp_d    = sp_q + SP_ONE;
                cur_d   = route_q[cur_q];
                code_d  = 2'd3;
                state_d = cur_q == src_q ? EMIT : sp_q == num_q - SP_ONE ? ERR : WALK;
            end
            EMIT: if (path_ready_i) begin
                sp_d    = sp_q - SP_ONE;
                state_d = sp_q == SP_ONE ? IDLE : EMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and walk registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            sp_q    <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            sp_q    <= sp_d;
            code_q  <= code_d;
        end
    end

    // path stack: the destination lands at the bottom so popping yields source-first order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_VIRTEX_NUM; i++) stack_q[i] <= '0;
        end else if (state_q == WALK) begin
            stack_q[sp_q[VW-1:0]] <= cur_q;
        end
    end

    // snapshot capture only while idle; strobes seen while busy are dropped and flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_VIRTEX_NUM; i++) begin
                dist_q[i]  <= '0;
                route_q[i] <= '0;
            end
            src_q    <= '0;
            num_q    <= '0;
            loaded_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else if (snap) begin
            for (int i = 0; i < MAX_VIRTEX_NUM; i++) begin
                dist_q[i]  <= dist_vect_i[i*DW +: DW];
                route_q[i] <= route_vect_i[i*VW +: VW];
            end
            src_q    <= src_virt_i;
            num_q    <= virt_num_i;
            loaded_q <= 1'b1;
            ovr_q    <= 1'b0;
        end else if (result_rdy_i) begin
            ovr_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dijkstra_path_tracer.sv
// tb_dijkstra_path_tracer: directed and randomized checks against a path-walking reference model
module tb_dijkstra_path_tracer;
    localparam int M = 16, VW = 4, DW = 16;

    logic clk = 0, rst = 1, result_rdy_i = 0, req_valid_i = 0, path_ready_i = 1;
    logic [DW*M-1:0] dist_vect_i = '0;
    logic [VW*M-1:0] route_vect_i = '0;
    logic [VW-1:0]   src_virt_i = '0, req_dst_i = '0;
    logic [VW:0]     virt_num_i = '0;
    logic            req_ready_o, path_valid_o, path_last_o, trace_err_o, busy_o, loaded_o, snap_ovr_o;
    logic [VW-1:0]   path_virt_o;
    logic [DW-1:0]   path_dist_o;
    logic [1:0]      err_code_o;

    dijkstra_path_tracer dut (
        .clk(clk), .rst(rst), .result_rdy_i(result_rdy_i), .dist_vect_i(dist_vect_i),
        .route_vect_i(route_vect_i), .src_virt_i(src_virt_i), .virt_num_i(virt_num_i),
        .req_valid_i(req_valid_i), .req_dst_i(req_dst_i), .req_ready_o(req_ready_o),
        .path_valid_o(path_valid_o), .path_ready_i(path_ready_i), .path_virt_o(path_virt_o),
        .path_dist_o(path_dist_o), .path_last_o(path_last_o), .trace_err_o(trace_err_o),
        .err_code_o(err_code_o), .busy_o(busy_o), .loaded_o(loaded_o), .snap_ovr_o(snap_ovr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (monitor) ----------------
    int   kind = 0, exp_cyc = 0, exp_code = 0;
    int   qv[$], qd[$], pth[$];
    logic [15:0] m_dist[16];
    logic [3:0]  m_route[16];
    int   m_src = 0, m_n = 0;
    bit   m_loaded = 0, m_ovr = 0;
    bit   pv_prev = 0, pr_prev = 0;
    int   v_prev = 0, d_prev = 0;

    always @(negedge clk) begin
        bit busy_m, rr, ok;
        int v;
        if (rst) begin
            kind = 0;
            qv.delete();
            qd.delete();
            m_loaded = 0;
            m_ovr = 0;
            pv_prev = 0;
        end else begin
            busy_m = kind != 0;
            rr = !busy_m && !result_rdy_i;
            chk("busy_o", busy_o, busy_m);
            chk("loaded_o", loaded_o, m_loaded);
            chk("snap_ovr_o", snap_ovr_o, m_ovr);
            chk("req_ready_o", req_ready_o, rr);
            if (kind == 2 && cyc >= exp_cyc) begin
                chk("path_valid_o", path_valid_o, 1);
                chk("path_virt_o", path_virt_o, qv[0]);
                chk("path_dist_o", path_dist_o, qd[0]);
                chk("path_last_o", path_last_o, qv.size() == 1);
                chk("trace_err_o", trace_err_o, 0);
                if (path_valid_o && path_ready_i) begin
                    void'(qv.pop_front());
                    void'(qd.pop_front());
                    if (qv.size() == 0) kind = 0;
                end
            end else begin
                chk("path_valid_o", path_valid_o, 0);
                if (kind == 1 && cyc == exp_cyc) begin
                    chk("trace_err_o", trace_err_o, 1);
                    chk("err_code_o", err_code_o, exp_code);
                    kind = 0;
                end else chk("trace_err_o", trace_err_o, 0);
            end
            if (pv_prev && !pr_prev) begin
                chk("hold_virt", path_virt_o, v_prev);
                chk("hold_dist", path_dist_o, d_prev);
            end
            pv_prev = path_valid_o;
            pr_prev = path_ready_i;
            v_prev = path_virt_o;
            d_prev = path_dist_o;
            if (result_rdy_i) begin
                if (!busy_m) begin
                    for (int i = 0; i < 16; i++) begin
                        m_dist[i] = dist_vect_i[i*DW +: DW];
                        m_route[i] = route_vect_i[i*VW +: VW];
                    end
                    m_src = src_virt_i;
                    m_n = virt_num_i;
                    m_loaded = 1;
                    m_ovr = 0;
                end else m_ovr = 1;
            end
            if (req_valid_i && rr) begin
                if (!m_loaded) begin kind = 1; exp_code = 0; exp_cyc = cyc + 1; end
                else if (int'(req_dst_i) >= m_n) begin kind = 1; exp_code = 1; exp_cyc = cyc + 1; end
                else if (m_dist[req_dst_i] == 16'hFFFF) begin kind = 1; exp_code = 2; exp_cyc = cyc + 1; end
                else begin
                    pth.delete();
                    v = req_dst_i;
                    ok = 0;
                    for (int k = 0; k < m_n; k++) begin
                        pth.push_front(v);
                        if (v == m_src) begin ok = 1; break; end
                        v = m_route[v];
                    end
                    if (ok) begin
                        kind = 2;
                        exp_cyc = cyc + pth.size() + 1;
                        foreach (pth[j]) begin
                            qv.push_back(pth[j]);
                            qd.push_back(m_dist[pth[j]]);
                        end
                    end else begin
                        kind = 1; exp_code = 3; exp_cyc = cyc + m_n + 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] sd[16];
    logic [3:0]  sr[16];
    int sn, ss, T;

    task automatic drive_snap();
        for (int i = 0; i < 16; i++) begin
            dist_vect_i[i*DW +: DW] = sd[i];
            route_vect_i[i*VW +: VW] = sr[i];
        end
        src_virt_i = ss[3:0];
        virt_num_i = sn[4:0];
    endtask

    task automatic set_common();
        for (int i = 0; i < 16; i++) begin sd[i] = 0; sr[i] = 0; end
        sn = 5; ss = 0;
        sd[1] = 2; sd[2] = 5; sd[3] = 4; sd[4] = 7;
        sr[2] = 1; sr[3] = 1; sr[4] = 3;
    endtask

    task automatic rand_snap();
        bit tree;
        sn = $urandom_range(16, 1);
        ss = $urandom_range(sn - 1, 0);
        tree = ($urandom % 3) != 0;
        for (int v = 0; v < 16; v++) begin
            sd[v] = ($urandom % 6 == 0) ? 16'hFFFF : 16'($urandom % 1000);
            sr[v] = 4'($urandom % 16);
            if (tree && v < sn)
                sr[v] = v == ss ? 4'(ss) : v > ss ? 4'($urandom_range(v - 1, ss)) : 4'($urandom_range(ss, v + 1));
        end
    endtask

    task automatic strobe();
        @(posedge clk); #1;
        drive_snap();
        result_rdy_i = 1;
        @(posedge clk); #1;
        result_rdy_i = 0;
    endtask

    task automatic query(input int dst);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid_i = 1;
        req_dst_i = dst[3:0];
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready_o) begin ok = 1; T = cyc; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("query_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid_i = 0;
    endtask

    task automatic wait_cyc(input int t);
        int k = 0;
        do begin @(negedge clk); k++; end while (cyc < t && k < 300);
        if (cyc != t) chk("wait_cyc", cyc, t);
    endtask

    task automatic beat(input string name, input int v, input int d, input int last);
        chk({name, "_valid"}, path_valid_o, 1);
        chk({name, "_virt"}, path_virt_o, v);
        chk({name, "_dist"}, path_dist_o, d);
        chk({name, "_last"}, path_last_o, last);
    endtask

    task automatic reset_vals(input string name);
        chk({name, "_req_ready"}, req_ready_o, 1);
        chk({name, "_path_valid"}, path_valid_o, 0);
        chk({name, "_path_last"}, path_last_o, 0);
        chk({name, "_trace_err"}, trace_err_o, 0);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_loaded"}, loaded_o, 0);
        chk({name, "_snap_ovr"}, snap_ovr_o, 0);
        chk({name, "_path_virt"}, path_virt_o, 0);
        chk({name, "_path_dist"}, path_dist_o, 0);
        chk({name, "_err_code"}, err_code_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bit acc = 0;
        repeat (2) @(negedge clk);
        reset_vals("reset");
        @(posedge clk); #1;
        rst = 0;

        // no snapshot loaded
        query(3);
        wait_cyc(T + 1);
        chk("nosnap_err", trace_err_o, 1);
        chk("nosnap_code", err_code_o, 0);
        wait_cyc(T + 2);
        chk("nosnap_ready", req_ready_o, 1);

        // basic path with a dropped strobe during EMIT
        set_common();
        strobe();
        chk("loaded_after_strobe", loaded_o, 1);
        query(4);
        wait_cyc(T + 4);
        chk("basic_not_yet", path_valid_o, 0);
        wait_cyc(T + 5);
        beat("basic0", 0, 0, 0);
        @(posedge clk); #1;
        dist_vect_i = '1;
        result_rdy_i = 1;
        wait_cyc(T + 6);
        beat("basic1", 1, 2, 0);
        @(posedge clk); #1;
        result_rdy_i = 0;
        wait_cyc(T + 7);
        beat("basic2", 3, 4, 0);
        wait_cyc(T + 8);
        beat("basic3", 4, 7, 1);
        wait_cyc(T + 9);
        chk("basic_ready_back", req_ready_o, 1);
        chk("basic_ovr", snap_ovr_o, 1);

        // backpressure on the second beat
        query(4);
        wait_cyc(T + 5);
        @(posedge clk); #1;
        path_ready_i = 0;
        for (int k = 6; k <= 8; k++) begin
            wait_cyc(T + k);
            beat("bp_hold", 1, 2, 0);
        end
        @(posedge clk); #1;
        path_ready_i = 1;
        wait_cyc(T + 11);
        beat("bp_last", 4, 7, 1);
        wait_cyc(T + 12);
        chk("bp_ready_back", req_ready_o, 1);

        // self path
        query(0);
        wait_cyc(T + 2);
        beat("self", 0, 0, 1);
        wait_cyc(T + 3);
        chk("self_done", path_valid_o, 0);

        // out of range
        query(6);
        wait_cyc(T + 1);
        chk("range_err", trace_err_o, 1);
        chk("range_code", err_code_o, 1);

        // unreachable destination
        set_common();
        sd[2] = 16'hFFFF;
        strobe();
        chk("ovr_cleared", snap_ovr_o, 0);
        query(2);
        wait_cyc(T + 1);
        chk("unreach_err", trace_err_o, 1);
        chk("unreach_code", err_code_o, 2);
        chk("unreach_novalid", path_valid_o, 0);

        // predecessor loop
        set_common();
        sr[4] = 3;
        sr[3] = 4;
        strobe();
        query(4);
        wait_cyc(T + 5);
        chk("loop_not_yet", trace_err_o, 0);
        wait_cyc(T + 6);
        chk("loop_err", trace_err_o, 1);
        chk("loop_code", err_code_o, 3);

        // strobe and query in the same cycle
        set_common();
        sd[4] = 11;
        @(posedge clk); #1;
        drive_snap();
        result_rdy_i = 1;
        req_valid_i = 1;
        req_dst_i = 4;
        @(negedge clk);
        chk("collide_stall", req_ready_o, 0);
        @(posedge clk); #1;
        result_rdy_i = 0;
        @(negedge clk);
        chk("collide_accept", req_ready_o, 1);
        T = cyc;
        @(posedge clk); #1;
        req_valid_i = 0;
        wait_cyc(T + 8);
        beat("collide_last", 4, 11, 1);

        // reset mid-WALK
        query(4);
        wait_cyc(T + 2);
        chk("walk_busy", busy_o, 1);
        #2 rst = 1;
        #1 reset_vals("midreset");
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        query(1);
        wait_cyc(T + 1);
        chk("postreset_code_err", trace_err_o, 1);
        chk("postreset_code", err_code_o, 0);

        // randomized traffic
        rand_snap();
        strobe();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (acc) req_valid_i = 0;
            result_rdy_i = ($urandom % 30) == 0;
            if (result_rdy_i) begin
                rand_snap();
                drive_snap();
            end
            if (!req_valid_i && ($urandom % 3) == 0) begin
                req_valid_i = 1;
                req_dst_i = 4'($urandom % 16);
            end
            path_ready_i = ($urandom % 4) != 0;
            @(negedge clk);
            acc = req_valid_i && req_ready_o;
        end
        @(posedge clk); #1;
        req_valid_i = 0;
        result_rdy_i = 0;
        path_ready_i = 1;
        repeat (60) @(negedge clk);
        chk("drained", kind, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
